// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, constants and round functions for the SHA-256 round engine
// Contents: state_t (FSM states), ROUNDS, IV (initial chaining value, H0 at [255:224]),
// big_sigma0/big_sigma1, small_sigma0/small_sigma1, ch, maj.
package sha256_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;
    localparam int ROUNDS = 64;
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction
    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction
endpackage

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: 16-word sliding message-schedule window producing W[i]
// Ports: clk, rst (sync, active-high), load (fill window from block), block (512-bit, W0 at [511:480]),
// advance (slide one word), w (current W[i]).
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [511:0] block,
    input  logic         advance,
    output logic [31:0]  w
);
    // win[k] holds W[i+k] while round i is executing
    logic [31:0] win [16];
    logic [31:0] w_new;
    assign w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
    assign w = win[0];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 16; j++) win[j] <= '0;
        end else if (load) begin
            for (int j = 0; j < 16; j++) win[j] <= block[511 - 32*j -: 32];
        end else if (advance) begin
            for (int j = 0; j < 15; j++) win[j] <= win[j + 1];
            win[15] <= w_new;
        end
    end
endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: one-round-per-cycle SHA-256 compression engine with block/digest handshakes
// Ports: clk, rst (sync, active-high); blk_valid/blk_ready/blk_data/blk_first (block input);
// k_load (restart pulse to the external K stream), k_in (K[i] during round i);
// dig_valid/dig_ready/digest (H0 at [255:224]).
// Build option: SHA256_MULTIBLOCK_EN chains blocks whose blk_first=0 from the previous digest;
// without it every block hashes independently from the IV.
module sha256_round_engine
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    output logic         k_load,
    input  logic [31:0]  k_in,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] digest
);
    state_t state, state_nx;
    logic [511:0] blk_reg;
    logic [31:0]  wv [8];
    logic [31:0]  wv_nx [8];
    logic [5:0]   cnt;
    logic [255:0] h_reg, init, sum;
    logic [31:0]  w, t1, t2;
    logic         sched_load, sched_adv;
`ifdef SHA256_MULTIBLOCK_EN
    logic first_reg;
    always_ff @(posedge clk) begin
        if (rst) first_reg <= 1'b0;
        else if (state == IDLE && blk_valid) first_reg <= blk_first;
    end
    assign init = first_reg ? IV : h_reg;
`else
    logic unused_first;
    assign unused_first = blk_first;
    assign init = IV;
`endif
    sha256_msg_schedule u_sched (
        .clk     (clk),
        .rst     (rst),
        .load    (sched_load),
        .block   (blk_reg),
        .advance (sched_adv),
        .w       (w)
    );
    assign t1 = wv[7] + big_sigma1(wv[4]) + ch(wv[4], wv[5], wv[6]) + k_in + w;
    assign t2 = big_sigma0(wv[0]) + maj(wv[0], wv[1], wv[2]);
    // Feed-forward uses the post-round registers so the final add lands on the round-63 edge
    always_comb begin
        wv_nx[0] = t1 + t2;
        wv_nx[1] = wv[0];
        wv_nx[2] = wv[1];
        wv_nx[3] = wv[2];
        wv_nx[4] = wv[3] + t1;
        wv_nx[5] = wv[4];
        wv_nx[6] = wv[5];
        wv_nx[7] = wv[6];
        sum = '0;
        for (int k = 0; k < 8; k++) sum[255 - 32*k -: 32] = h_reg[255 - 32*k -: 32] + wv_nx[k];
    end
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = state == IDLE  ? (blk_valid ? LOAD : IDLE) :
                   state == LOAD  ? ROUND :
                   state == ROUND ? (cnt == 6'(ROUNDS - 1) ? DONE : ROUND) :
                                    (dig_ready ? IDLE : DONE);
    end
    always_comb begin
        blk_ready  = state == IDLE;
        k_load     = state == LOAD;
        dig_valid  = state == DONE;
        sched_load = state == LOAD;
        sched_adv  = state == ROUND;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_reg <= '0;
            cnt     <= '0;
            h_reg   <= IV;
            digest  <= '0;
            for (int k = 0; k < 8; k++) wv[k] <= '0;
        end else begin
            if (state == IDLE && blk_valid) blk_reg <= blk_data;
            if (state == LOAD) begin
                cnt   <= '0;
                h_reg <= init;
                for (int k = 0; k < 8; k++) wv[k] <= init[255 - 32*k -: 32];
            end
            if (state == ROUND) begin
                cnt <= cnt + 6'd1;
                for (int k = 0; k < 8; k++) wv[k] <= wv_nx[k];
                if (cnt == 6'(ROUNDS - 1)) begin
                    h_reg  <= sum;
                    digest <= sum;
                end
            end
        end
    end
endmodule
